proc_sequencer: RTL and testbench
=================================

Name: proc_sequencer

Overview:
- Instruction-issuing master for the 9-bit mv/mvi/add/sub processor; drives the processor's DIN and Run and watches its Done.
- Holds a small loadable program memory and issues words one at a time from address 0.
- For mvi, presents the operand word in the processor's T1 cycle.
- Stops on a halt word or at end of memory, and flags a protocol error if Done never arrives.

Parameters:
DEPTH, 32, number of 9-bit program words
AW, 5, address width; DEPTH = 2**AW
TMO, 4, max WAIT cycles without ProcDone before error

Ports:
Clock  input  1  clock, all state changes on rising edge
Resetn  input  1  reset, asynchronous, active-low
Start  input  1  begin execution at address 0; sampled in IDLE only
LdEn  input  1  program-memory write enable; honoured only when Busy=0
LdAddr  input  AW  program-memory write address
LdData  input  9  program-memory write data
ProcDone  input  1  processor Done (combinational, same cycle as its last step)
DIN  output  9  instruction/operand word to processor
Run  output  1  start-instruction strobe to processor
Busy  output  1  high in every state except IDLE
SeqDone  output  1  one-cycle pulse on normal completion
Error  output  1  sticky protocol/range error; cleared by Start
PC  output  AW  address of current instruction word
InstrCount  output  8  completed instructions since Start, saturates at 255

Behaviour:
- Reset (async):
  - state=IDLE; PC=0, Run=0, DIN=0, Busy=0, SeqDone=0, Error=0, InstrCount=0.
  - Memory contents are not reset and survive reset.
  - Reset mid-operation aborts immediately; no further Run.
- Memory: asynchronous read; synchronous write on Clock when LdEn & ~Busy. LdEn while Busy is ignored.
- Word format: [8:6] opcode, [5:3] X, [2:0] Y. Opcode 001 = mvi (two words). Opcode 111 = halt. 100/101/110 are issued as single-word instructions.
- Outputs are decoded from the current state (Moore):
  - DIN=mem[PC] in ISSUE; DIN=mem[PC+1] in OPERAND; DIN=0 otherwise.
  - Run=1 only in ISSUE.
- States:
  - IDLE: on Start → PC<=0, InstrCount<=0, Error<=0, go CHECK. Otherwise stay.
  - CHECK:
    - opcode(mem[PC])==111 → FINISH.
    - mvi with PC==DEPTH-1 → Error<=1, IDLE, no Run.
    - Otherwise → ISSUE.
  - ISSUE: Run=1 for exactly one cycle. Next state is OPERAND if mvi, else WAIT. Clear timeout counter.
  - OPERAND: operand on DIN; processor asserts ProcDone this cycle.
    - ProcDone=1 → PC<=PC+2, count++.
    - ProcDone=0 → go WAIT (operand no longer driven; timeout applies).
  - WAIT: timeout counter increments each cycle.
    - ProcDone=1 → PC<=PC+1, count++.
    - Counter reaches TMO without ProcDone → Error<=1, IDLE.
  - Completion (from OPERAND or WAIT): if the new PC wrapped past DEPTH-1, go FINISH; else CHECK.
  - FINISH: SeqDone=1 for one cycle, then IDLE.
- Boundary and timing rules:
  - Start while Busy is ignored.
  - Start and LdEn in the same IDLE cycle: the write occurs and Start begins; the written word is visible if its address is 0.
  - InstrCount saturates at 255; halt is not counted.
  - Handshake latency per instruction: ISSUE→ProcDone is 1 cycle (mv/mvi) or 3 cycles (add/sub). CHECK adds 1 cycle between instructions.
  - ProcDone outside OPERAND/WAIT is ignored.

Test Plan:
1. Load mem[0]=9'h040 (mvi r0), mem[1]=5, mem[2]=9'h008 (mv r1,r0), mem[3]=9'h081 (add r0,r1), mem[4]=9'h1C0 (halt); Start with the processor attached → Run pulses 3 times, DIN=9'h040 then 5 on consecutive cycles, SeqDone pulse, InstrCount=3, PC=4, Error=0, processor r0=10.
2. Processor model that never asserts ProcDone, mem[0]=9'h081 → Run once, Error=1 after 4 WAIT cycles, Busy=0, no SeqDone.
3. mem[DEPTH-1]=9'h040, other words mv (9'h008); Start → 31 instructions complete, then Error=1 with no Run at PC=31.
4. All 32 words mv, no halt → 32 Run pulses, PC wraps to 0, SeqDone once, InstrCount=32.
5. Assert Resetn=0 in WAIT during an add → Run=0, Busy=0, Error=0 immediately. Re-Start → program reruns from address 0 with memory intact.
6. LdEn with LdAddr=0, LdData=9'h1C0 while Busy → mem[0] unchanged. Same write in IDLE, then Start → SeqDone with zero Run pulses, InstrCount=0.

Source files
------------

// File: rtl/proc_sequencer_if.sv
// proc_sequencer_if: instruction handshake between the sequencer and the 9-bit processor.
interface proc_sequencer_if;
    logic [8:0] DIN;
    logic       Run;
    logic       ProcDone;
    modport master(output DIN, Run, input ProcDone);
    modport slave(input DIN, Run, output ProcDone);
endinterface

// File: rtl/proc_sequencer.sv
// proc_sequencer: issues a loaded 9-bit program to the mv/mvi/add/sub processor one word at a time.
module proc_sequencer #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int TMO   = 4
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Start,
    input  logic          LdEn,
    input  logic [AW-1:0] LdAddr,
    input  logic [8:0]    LdData,
    proc_sequencer_if.master bus,
    output logic          Busy,
    output logic          SeqDone,
    output logic          Error,
    output logic [AW-1:0] PC,
    output logic [7:0]    InstrCount
);
    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] TLIM = TW'(TMO - 1);
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, OPERAND, WAIT, FINISH} state_t;
    state_t state, nxt;
    logic [8:0] mem [DEPTH];
    logic [8:0] word;
    logic mvi, halt, last, err_n;
    logic [AW:0] step;
    logic [AW-1:0] pc_n;
    logic [7:0] cnt_n;
    logic [TW-1:0] tmo, tmo_n;
    assign word = mem[PC];
    assign mvi  = word[8:6] == 3'b001;
    assign halt = word[8:6] == 3'b111;
    assign last = PC == AW'(DEPTH - 1);
    // carry out of step marks the PC wrapping past the last word
    assign step = {1'b0, PC} + (state == OPERAND ? (AW+1)'(2) : (AW+1)'(1));
    assign bus.Run = state == ISSUE;
    assign bus.DIN = state == ISSUE ? word : state == OPERAND ? mem[PC + AW'(1)] : 9'd0;
    assign Busy    = state != IDLE;
    assign SeqDone = state == FINISH;
    always_ff @(posedge Clock)
        if (LdEn && !Busy) mem[LdAddr] <= LdData;
    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) state <= IDLE;
        else state <= nxt;
    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) begin
            PC <= '0;
            InstrCount <= '0;
            Error <= 1'b0;
            tmo <= '0;
        end else begin
            PC <= pc_n;
            InstrCount <= cnt_n;
            Error <= err_n;
            tmo <= tmo_n;
        end
    always_comb begin
        nxt = state;
        pc_n = PC;
        cnt_n = InstrCount;
        err_n = Error;
        tmo_n = tmo;
        case (state)
            IDLE:
                if (Start) begin
                    pc_n = '0;
                    cnt_n = '0;
                    err_n = 1'b0;
                    nxt = CHECK;
                end
            CHECK:
                if (halt) nxt = FINISH;
                else if (mvi && last) begin
                    err_n = 1'b1;
                    nxt = IDLE;
                end else nxt = ISSUE;
            ISSUE: begin
                tmo_n = '0;
                nxt = mvi ? OPERAND : WAIT;
            end
            OPERAND, WAIT:
                if (bus.ProcDone) begin
                    pc_n = step[AW-1:0];
                    cnt_n = InstrCount + 8'(InstrCount != 8'hFF);
                    nxt = step[AW] ? FINISH : CHECK;
                end else if (state == OPERAND) nxt = WAIT;
                else if (tmo == TLIM) begin
                    err_n = 1'b1;
                    nxt = IDLE;
                end else tmo_n = tmo + TW'(1);
            FINISH: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_proc_sequencer.sv
// tb_proc_sequencer: directed program runs against a behavioural mv/mvi/add/sub processor.
module tb_proc_sequencer;
    logic Clock = 0, Resetn = 1, Start = 0, LdEn = 0;
    logic [4:0] LdAddr = 0;
    logic [8:0] LdData = 0;
    logic Busy, SeqDone, Error;
    logic [4:0] PC;
    logic [7:0] InstrCount;
    proc_sequencer_if ifc();
    proc_sequencer dut(.Clock(Clock), .Resetn(Resetn), .Start(Start), .LdEn(LdEn), .LdAddr(LdAddr),
        .LdData(LdData), .bus(ifc), .Busy(Busy), .SeqDone(SeqDone), .Error(Error), .PC(PC),
        .InstrCount(InstrCount));
    always #5 Clock = ~Clock;

    // processor: Done in T1 for mv/mvi, in T3 for add/sub; en=0 models a dead processor
    logic en = 1;
    logic [1:0] t;
    logic [8:0] ir;
    logic [8:0] r [8];
    assign ifc.ProcDone = en && t != 0 && ((ir[8:7] == 2'b00 && t == 1) || (ir[8:7] == 2'b01 && t == 3));
    always @(posedge Clock or negedge Resetn)
        if (!Resetn) t <= 0;
        else if (t == 0) begin
            if (ifc.Run) begin
                ir <= ifc.DIN;
                t <= 1;
            end
        end else if (ifc.ProcDone) begin
            t <= 0;
            case (ir[8:6])
                3'b000: r[ir[5:3]] <= r[ir[2:0]];
                3'b001: r[ir[5:3]] <= ifc.DIN;
                3'b010: r[ir[5:3]] <= r[ir[5:3]] + r[ir[2:0]];
                default: r[ir[5:3]] <= r[ir[5:3]] - r[ir[2:0]];
            endcase
        end else t <= t + 1;

    int runs = 0, dones = 0, busy_cyc = 0, d0 = 0, d1 = 0;
    logic grab = 0;
    always @(negedge Clock) begin
        if (ifc.Run) begin
            if (runs == 0) begin
                d0 = ifc.DIN;
                grab = 1;
            end
            runs++;
        end else if (grab) begin
            d1 = ifc.DIN;
            grab = 0;
        end
        if (SeqDone) dones++;
        if (Busy) busy_cyc++;
    end

    int nchk = 0, nerr = 0;
    task automatic check(input string tag, input int got, input int exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int a, input int d);
        @(negedge Clock);
        LdEn = 1;
        LdAddr = 5'(a);
        LdData = 9'(d);
        @(negedge Clock);
        LdEn = 0;
    endtask

    task automatic clear;
        runs = 0;
        dones = 0;
        busy_cyc = 0;
    endtask

    task automatic go;
        @(negedge Clock);
        clear();
        Start = 1;
        @(negedge Clock);
        Start = 0;
    endtask

    task automatic finish_run(input string tag);
        int n = 0;
        while (Busy && n < 600) begin
            @(negedge Clock);
            n++;
        end
        check({tag, "_idle"}, int'(Busy), 0);
    endtask

    initial begin
        #1 Resetn = 0;
        repeat (3) @(negedge Clock);
        check("rst_run", int'(ifc.Run), 0);
        check("rst_din", int'(ifc.DIN), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_seqdone", int'(SeqDone), 0);
        check("rst_err", int'(Error), 0);
        check("rst_pc", int'(PC), 0);
        check("rst_cnt", int'(InstrCount), 0);
        Resetn = 1;

        load(0, 9'h040); load(1, 5); load(2, 9'h008); load(3, 9'h081); load(4, 9'h1C0);
        go();
        finish_run("t1");
        check("t1_runs", runs, 3);
        check("t1_din0", d0, 9'h040);
        check("t1_din1", d1, 5);
        check("t1_dones", dones, 1);
        check("t1_cnt", int'(InstrCount), 3);
        check("t1_pc", int'(PC), 4);
        check("t1_err", int'(Error), 0);
        check("t1_r0", int'(r[0]), 10);
        check("t1_busy_cyc", busy_cyc, 13);

        en = 0;
        load(0, 9'h081);
        go();
        finish_run("t2");
        check("t2_runs", runs, 1);
        check("t2_err", int'(Error), 1);
        check("t2_dones", dones, 0);
        check("t2_busy_cyc", busy_cyc, 6);
        check("t2_cnt", int'(InstrCount), 0);
        en = 1;

        load(1, 9'h1C0);
        go();
        check("t5_err_cleared", int'(Error), 0);
        @(negedge Clock);
        @(negedge Clock);
        Resetn = 0;
        #1;
        check("t5_run", int'(ifc.Run), 0);
        check("t5_busy", int'(Busy), 0);
        check("t5_err", int'(Error), 0);
        check("t5_pc", int'(PC), 0);
        repeat (3) @(negedge Clock);
        check("t5_no_run", runs, 1);
        Resetn = 1;
        go();
        finish_run("t5b");
        check("t5b_runs", runs, 1);
        check("t5b_cnt", int'(InstrCount), 1);
        check("t5b_pc", int'(PC), 1);
        check("t5b_dones", dones, 1);

        for (int i = 0; i < 31; i++) load(i, 9'h008);
        load(31, 9'h040);
        go();
        finish_run("t3");
        check("t3_runs", runs, 31);
        check("t3_cnt", int'(InstrCount), 31);
        check("t3_pc", int'(PC), 31);
        check("t3_err", int'(Error), 1);
        check("t3_dones", dones, 0);

        load(31, 9'h008);
        go();
        finish_run("t4");
        check("t4_runs", runs, 32);
        check("t4_pc", int'(PC), 0);
        check("t4_dones", dones, 1);
        check("t4_cnt", int'(InstrCount), 32);
        check("t4_err", int'(Error), 0);

        load(1, 9'h1C0);
        go();
        LdEn = 1;
        LdAddr = 0;
        LdData = 9'h1C0;
        @(negedge Clock);
        LdEn = 0;
        finish_run("t6a");
        check("t6a_runs", runs, 1);
        go();
        finish_run("t6b");
        check("t6b_runs", runs, 1);
        @(negedge Clock);
        clear();
        LdEn = 1;
        LdAddr = 0;
        LdData = 9'h1C0;
        Start = 1;
        @(negedge Clock);
        LdEn = 0;
        Start = 0;
        finish_run("t6c");
        check("t6c_runs", runs, 0);
        check("t6c_dones", dones, 1);
        check("t6c_cnt", int'(InstrCount), 0);
        check("t6c_pc", int'(PC), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
